// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame scheduler.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWait,
        StDone,
        StAbort
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // sync + source id + payload + checksum
    function automatic int unsigned frame_len(input int unsigned payload_bytes);
        return payload_bytes + 3;
    endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Requester-side and serializer-side signals of the frame scheduler.
interface uart_frame_scheduler_if #(
    parameter int unsigned N_SRC         = 4,
    parameter int unsigned Word          = 8,
    parameter int unsigned PAYLOAD_BYTES = 2
);

    logic [N_SRC-1:0]                    req;
    logic [N_SRC*PAYLOAD_BYTES*Word-1:0] payload;
    logic [N_SRC-1:0]                    grant;
    logic                                tx_en;
    logic [Word-1:0]                     tx_data;
    logic                                tx_done;
    logic                                busy;
    logic                                frame_sent;
    logic                                err;

    modport master (
        input  req, payload, tx_done,
        output grant, tx_en, tx_data, busy, frame_sent, err
    );

    modport slave (
        output req, payload, tx_done,
        input  grant, tx_en, tx_data, busy, frame_sent, err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap-around.
module rr_arbiter #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_SRC-1:0] winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            cand = IDX_W'((32'(rr_ptr) + i) % N_SRC);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                winner[cand] = 1'b1;
                winner_idx  = cand;
            end
        end
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Round-robin frame scheduler: grants one sensor, frames its payload and sequences the bytes
// through the serializer's enable/done handshake with a per-byte watchdog.
module uart_frame_scheduler
    import uart_frame_pkg::*;
#(
    parameter int unsigned N_SRC         = 4,
    parameter int unsigned Word          = 8,
    parameter int unsigned PAYLOAD_BYTES = 2,
    parameter int unsigned TIMEOUT_CYC   = 166640,
    parameter int unsigned TO_W          = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_frame_scheduler_if.master bus
);

    localparam int unsigned FRAME_LEN = frame_len(PAYLOAD_BYTES);
    localparam int unsigned SLICE_W   = PAYLOAD_BYTES * Word;
    localparam int unsigned SRC_W     = $clog2(N_SRC);
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

    state_e           state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [Word-1:0]  frame_q [FRAME_LEN];
    logic [Word-1:0]  frame_d [FRAME_LEN];
    logic             load_frame;

    logic [N_SRC-1:0]   arb_winner;
    logic [SRC_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [SLICE_W-1:0] sel_payload;
    logic [Word-1:0]    chk;

    rr_arbiter #(
        .N_SRC (N_SRC),
        .IDX_W (SRC_W)
    ) u_arb (
        .req        (bus.req),
        .rr_ptr     (rr_ptr_q),
        .winner     (arb_winner),
        .winner_idx (arb_idx),
        .valid      (arb_valid)
    );

    // Candidate frame for the current arbitration winner; only latched on grant.
    always_comb begin
        frame_d     = '{default: '0};
        sel_payload = bus.payload[32'(arb_idx)*SLICE_W +: SLICE_W];
        frame_d[0]  = Word'(SYNC_BYTE);
        frame_d[1]  = Word'(arb_idx);
        for (int unsigned b = 0; b < PAYLOAD_BYTES; b++) begin
            frame_d[2+b] = sel_payload[(PAYLOAD_BYTES-1-b)*Word +: Word];
        end
        chk = '0;
        for (int unsigned b = 1; b < FRAME_LEN - 1; b++) begin
            chk = chk ^ frame_d[b];
        end
        frame_d[FRAME_LEN-1] = chk;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        idx_d      = idx_q;
        wd_d       = wd_q;
        grant_d    = '0;
        load_frame = 1'b0;
        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    grant_d    = arb_winner;
                    owner_d    = arb_idx;
                    load_frame = 1'b1;
                    idx_d      = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                if (bus.tx_done) begin
                    if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StSend;
                    end
                end else if (wd_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = StAbort;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StDone, StAbort: begin
                rr_ptr_d = (owner_q == SRC_W'(N_SRC - 1)) ? '0 : owner_q + 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            idx_q    <= '0;
            wd_q     <= '0;
            grant_q  <= '0;
            frame_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            idx_q    <= idx_d;
            wd_q     <= wd_d;
            grant_q  <= grant_d;
            if (load_frame) begin
                frame_q <= frame_d;
            end
        end
    end

    assign bus.grant      = grant_q;
    assign bus.tx_en      = (state_q == StSend);
    assign bus.tx_data    = frame_q[idx_q];
    assign bus.busy       = (state_q != StIdle);
    assign bus.frame_sent = (state_q == StDone);
    assign bus.err        = (state_q == StAbort);

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler with a behavioural serializer (fixed done delay).
module tb_uart_frame_scheduler;

    localparam int DLY = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic model_on = 1'b1;
    logic model_done = 1'b0;
    logic spur_done = 1'b0;
    int   cnt = -1;
    int   cyc = 0;

    int total = 0;
    int bad = 0;

    logic [7:0] rxq[$];
    logic [3:0] gq[$];
    int         gcq[$];
    int         fsq[$];
    int         fs_cnt = 0;
    int         err_cnt = 0;
    int         err_cyc = 0;
    int         last_txen_cyc = 0;

    uart_frame_scheduler_if #(.N_SRC(4), .Word(8), .PAYLOAD_BYTES(2)) bus ();

    uart_frame_scheduler #(
        .N_SRC         (4),
        .Word          (8),
        .PAYLOAD_BYTES (2),
        .TIMEOUT_CYC   (32),
        .TO_W          (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.tx_done = model_done | spur_done;

    // Serializer model plus event recorder, both on the falling edge.
    always @(negedge clk) begin
        model_done = 1'b0;
        if (cnt > 0) cnt--;
        else if (cnt == 0) begin
            model_done = model_on;
            cnt = -1;
        end
        if (bus.tx_en) begin
            rxq.push_back(bus.tx_data);
            cnt = DLY;
            last_txen_cyc = cyc;
        end
        if (bus.grant != 4'b0000) begin
            gq.push_back(bus.grant);
            gcq.push_back(cyc);
        end
        if (bus.frame_sent) begin
            fs_cnt++;
            fsq.push_back(cyc);
        end
        if (bus.err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 400000");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        bus.req = 4'b0000;
        spur_done = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rxq.delete();
        gq.delete();
        gcq.delete();
        fsq.delete();
        fs_cnt = 0;
        err_cnt = 0;
    endtask

    // Drops each granted request and returns once n frames have ended (sent or aborted).
    task automatic serve(input int n, input int budget, output bit ok);
        int start;
        start = fs_cnt + err_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.grant != 4'b0000) bus.req = bus.req & ~bus.grant;
            if (fs_cnt + err_cnt - start >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        total++;
        if (bus.grant !== 4'b0000) begin
            bad++;
            $display("FAIL reset_grant: got %b want 0000", bus.grant);
        end
        total++;
        if (bus.tx_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_tx_en: got %b want 0", bus.tx_en);
        end
        total++;
        if (bus.tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_tx_data: got %h want 00", bus.tx_data);
        end
        total++;
        if ({bus.busy, bus.frame_sent, bus.err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.frame_sent, bus.err});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [7:0] exp [5];
        bit ok;
        exp = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h24};
        reset_dut();
        bus.payload = {16'hFFFF, 16'h1234, 16'hAAAA, 16'h5555};
        bus.req = 4'b0100;
        step();
        total++;
        if (bus.grant !== 4'b0100) begin
            bad++;
            $display("FAIL single_grant: got %b want 0100", bus.grant);
        end
        total++;
        if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'hA5) begin
            bad++;
            $display("FAIL single_first_tx: got en=%b data=%h want en=1 data=a5",
                     bus.tx_en, bus.tx_data);
        end
        bus.req = 4'b0000;
        step();
        total++;
        if (bus.grant !== 4'b0000) begin
            bad++;
            $display("FAIL single_grant_pulse: got %b want 0000", bus.grant);
        end
        serve(1, 200, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL single_done_wait: got ok=%b want 1", ok);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rxq.size() <= i || rxq[i] !== exp[i]) begin
                bad++;
                $display("FAIL single_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
        step();
        total++;
        if (rxq.size() != 5 || fs_cnt != 1 || err_cnt != 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_tail: got bytes=%0d sent=%0d err=%0d busy=%b want 5 1 0 0",
                     rxq.size(), fs_cnt, err_cnt, bus.busy);
        end
    endtask

    task automatic test_all();
        logic [3:0] exp [6];
        bit ok;
        exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000};
        reset_dut();
        bus.payload = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus.req = 4'b1111;
        serve(4, 600, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL all_wait: got ok=%b want 1", ok);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rxq.size() <= 5*i+1 || rxq[5*i+1] !== 8'(i)) begin
                bad++;
                $display("FAIL all_src_id%0d: got %h want %h", i, rxq[5*i+1], 8'(i));
            end
        end
        bus.req = 4'b1001;
        serve(2, 300, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL all_rerequest_wait: got ok=%b want 1", ok);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (gq.size() <= i || gq[i] !== exp[i]) begin
                bad++;
                $display("FAIL all_grant%0d: got %b want %b", i, gq[i], exp[i]);
            end
        end
    endtask

    task automatic test_mid();
        logic [7:0] exp [10];
        bit ok;
        exp = '{8'hA5, 8'h00, 8'hBE, 8'hEF, 8'h51, 8'hA5, 8'h01, 8'h55, 8'h66, 8'h32};
        reset_dut();
        bus.payload = {16'h0000, 16'h0000, 16'h5566, 16'hBEEF};
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0000;
        for (int i = 0; i < 6; i++) step();
        bus.payload = {16'h0000, 16'h0000, 16'h5566, 16'h0000};
        bus.req = 4'b0010;
        serve(2, 300, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL mid_wait: got ok=%b want 1", ok);
        end
        total++;
        if (gq.size() != 2 || gq[0] !== 4'b0001 || gq[1] !== 4'b0010) begin
            bad++;
            $display("FAIL mid_grant_order: got n=%0d %b %b want 2 0001 0010",
                     gq.size(), gq[0], gq[1]);
        end
        total++;
        if (gcq.size() < 2 || fsq.size() < 1 || gcq[1] - fsq[0] != 2) begin
            bad++;
            $display("FAIL mid_grant_gap: got %0d want 2", gcq[1] - fsq[0]);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (rxq.size() <= i || rxq[i] !== exp[i]) begin
                bad++;
                $display("FAIL mid_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        reset_dut();
        model_on = 1'b0;
        bus.payload = {16'h0000, 16'h9999, 16'h0000, 16'h0000};
        bus.req = 4'b0100;
        serve(1, 100, ok);
        total++;
        if (ok !== 1'b1 || err_cnt != 1 || fs_cnt != 0) begin
            bad++;
            $display("FAIL wd_abort: got ok=%b err=%0d sent=%0d want 1 1 0", ok, err_cnt, fs_cnt);
        end
        total++;
        if (err_cyc - last_txen_cyc != 33) begin
            bad++;
            $display("FAIL wd_latency: got %0d want 33", err_cyc - last_txen_cyc);
        end
        step();
        total++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL wd_idle: got busy=%b err=%b want 0 0", bus.busy, bus.err);
        end
        model_on = 1'b1;
        bus.req = 4'b1001;
        serve(2, 300, ok);
        total++;
        if (ok !== 1'b1 || gq.size() != 3 || gq[1] !== 4'b1000 || gq[2] !== 4'b0001) begin
            bad++;
            $display("FAIL wd_next_grant: got ok=%b n=%0d %b %b want 1 3 1000 0001",
                     ok, gq.size(), gq[1], gq[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [5];
        logic [15:0] got;
        bit ok;
        exp = '{8'hA5, 8'h03, 8'hC3, 8'hD2, 8'h12};
        reset_dut();
        bus.payload = {16'hC3D2, 16'h0000, 16'h7777, 16'h0000};
        bus.req = 4'b0010;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            bus.req = bus.req & ~bus.grant;
            if (rxq.size() == 3) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_reach_byte2: got ok=%b want 1", ok);
        end
        rst = 1'b0;
        step();
        got = {bus.grant, bus.tx_en, bus.tx_data, bus.busy, bus.frame_sent, bus.err};
        total++;
        if (got !== 16'h0000) begin
            bad++;
            $display("FAIL rstmid_outputs: got %h want 0000", got);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step();
        total++;
        if (fs_cnt != 0 || err_cnt != 0) begin
            bad++;
            $display("FAIL rstmid_no_events: got sent=%0d err=%0d want 0 0", fs_cnt, err_cnt);
        end
        rxq.delete();
        bus.req = 4'b1000;
        serve(1, 200, ok);
        total++;
        if (ok !== 1'b1 || rxq.size() != 5) begin
            bad++;
            $display("FAIL rstmid_frame: got ok=%b bytes=%0d want 1 5", ok, rxq.size());
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rxq.size() <= i || rxq[i] !== exp[i]) begin
                bad++;
                $display("FAIL rstmid_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
    endtask

    task automatic test_spurious();
        logic [7:0] exp [5];
        bit ok;
        exp = '{8'hA5, 8'h00, 8'h0F, 8'h0F, 8'h00};
        reset_dut();
        bus.payload = {16'h0000, 16'h0000, 16'h0000, 16'h0F0F};
        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        step();
        total++;
        if (bus.busy !== 1'b0 || bus.tx_en !== 1'b0 || gq.size() != 0) begin
            bad++;
            $display("FAIL spur_idle: got busy=%b tx_en=%b grants=%0d want 0 0 0",
                     bus.busy, bus.tx_en, gq.size());
        end
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0000;
        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        serve(1, 200, ok);
        total++;
        if (ok !== 1'b1 || rxq.size() != 5) begin
            bad++;
            $display("FAIL spur_frame: got ok=%b bytes=%0d want 1 5", ok, rxq.size());
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rxq.size() <= i || rxq[i] !== exp[i]) begin
                bad++;
                $display("FAIL spur_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
    endtask

    initial begin
        bus.req = 4'b0000;
        bus.payload = '0;
        test_reset();
        test_single();
        test_all();
        test_mid();
        test_watchdog();
        test_reset_mid();
        test_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
